// File: rtl/usr_shift_ctrl_if.sv
// Command/result channel between a requester and usr_shift_ctrl; valid/ready accept, one-cycle done pulse.
// cmd_rotate exists only when USR_ROTATE_EN is defined.
interface usr_shift_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
`ifdef USR_ROTATE_EN
    logic             cmd_rotate;
`endif
    logic             done;
    logic [WIDTH-1:0] res_data;

    modport master (
`ifdef USR_ROTATE_EN
        output cmd_rotate,
`endif
        output cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_fill,
        input  cmd_ready, done, res_data
    );

    modport slave (
`ifdef USR_ROTATE_EN
        input  cmd_rotate,
`endif
        input  cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_fill,
        output cmd_ready, done, res_data
    );
endinterface

// File: rtl/usr_shift_ctrl.sv
// USR sequencer: load, cmd_count shifts, hold, then done pulse count+2 cycles after accept; one job in flight, cmd_ready only in IDLE.
// Optional USR_ROTATE_EN: latched cmd_rotate replaces the fill bit with q_in feedback (rotate).
module usr_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    usr_shift_ctrl_if.slave   cmd,
    input  logic              abort,
    output logic [1:0]        s,
    output logic [WIDTH-1:0]  b,
    output logic              sr,
    output logic              sl,
    input  logic [WIDTH-1:0]  q_in,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic             done_q, done_d;
    logic             accept;
    logic             ser_bit;

    assign cmd.cmd_ready = (state_q == IDLE) & rst;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign busy          = (state_q != IDLE);
    assign cmd.done      = done_q;
    assign cmd.res_data  = res_q;

`ifdef USR_ROTATE_EN
    logic rot_q, rot_d;

    always_ff @(posedge clk) begin
        if (!rst) rot_q <= 1'b0;
        else      rot_q <= rot_d;
    end

    always_comb begin
        rot_d = rot_q;
        if (accept) rot_d = cmd.cmd_rotate;
    end

    // Feedback takes the bit about to fall off the far end of the register.
    assign ser_bit = rot_q ? (dir_q ? q_in[WIDTH-1] : q_in[0]) : fill_q;
`else
    assign ser_bit = fill_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = cmd.cmd_data;
                    dir_d   = cmd.cmd_dir;
                    cnt_d   = cmd.cmd_count;
                    fill_d  = cmd.cmd_fill;
                    state_d = LOAD;
                end
            end
            LOAD:  state_d = (cnt_q != '0) ? SHIFT : DONE;
            SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                res_d   = q_in;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over every in-flight transition, including the capture in DONE.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            res_d   = res_q;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        s  = 2'b00;
        b  = '0;
        sr = 1'b0;
        sl = 1'b0;
        case (state_q)
            LOAD: begin
                s = 2'b11;
                b = data_q;
            end
            SHIFT: begin
                if (dir_q) begin
                    s  = 2'b10;
                    sl = ser_bit;
                end else begin
                    s  = 2'b01;
                    sr = ser_bit;
                end
            end
            default: s = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Bench for usr_shift_ctrl: directed test-plan jobs then random jobs against a result/latency model; USR modelled behaviourally.
module tb_usr_shift_ctrl;
    localparam int W = 4;
    localparam int C = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   s;
    logic [W-1:0] b;
    logic         sr, sl, busy;
    logic [W-1:0] usr_q = '0;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] res_exp = '0;

    usr_shift_ctrl_if #(.WIDTH(W), .CNT_W(C)) cif ();

    usr_shift_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cif),
        .abort (abort),
        .s     (s),
        .b     (b),
        .sr    (sr),
        .sl    (sl),
        .q_in  (usr_q),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (s)
            2'b01:   usr_q <= {sr, usr_q[W-1:1]};
            2'b10:   usr_q <= {usr_q[W-2:0], sl};
            2'b11:   usr_q <= b;
            default: usr_q <= usr_q;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Final register after cnt shifts, from the shift rules directly.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input logic dir,
                                                 input int cnt, input logic fill, input logic rot);
        logic [W-1:0] r;
        r = d;
        for (int i = 0; i < cnt; i++) begin
            if (dir) r = (r << 1) | (rot ? W'(r[W-1]) : W'(fill));
            else     r = (r >> 1) | ((rot ? W'(r[0]) : W'(fill)) << (W-1));
        end
        return r;
    endfunction

    task automatic set_rot(input logic rot);
`ifdef USR_ROTATE_EN
        cif.cmd_rotate = rot;
`else
        if (rot) $display("note: rotate requested without USR_ROTATE_EN");
`endif
    endtask

    // abort_ph: -1 none, 0 = LOAD cycle, 1..cnt = SHIFT cycles, cnt+1 = DONE cycle.
    task automatic run_job(input logic [W-1:0] d, input logic dir, input int cnt,
                           input logic fill, input logic rot, input int abort_ph);
        logic [W-1:0] r;
        logic         ser;
        int           wait_cyc;
        wait_cyc = 0;
        while (cif.cmd_ready !== 1'b1 && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        chk("cmd_ready", cif.cmd_ready, 1);
        cif.cmd_valid = 1'b1;
        cif.cmd_data  = d;
        cif.cmd_dir   = dir;
        cif.cmd_count = C'(cnt);
        cif.cmd_fill  = fill;
        set_rot(rot);
        step();
        cif.cmd_valid = 1'b0;
        cif.cmd_data  = W'($urandom);
        cif.cmd_count = C'($urandom);
        r = d;
        for (int p = 0; p <= cnt + 1; p++) begin
            #1;
            if (p == 0) begin
                chk("load_s", s, 2'b11);
                chk("load_b", b, d);
            end else if (p <= cnt) begin
                ser = rot ? (dir ? r[W-1] : r[0]) : fill;
                chk("shift_s", s, dir ? 2'b10 : 2'b01);
                chk("shift_sr", sr, dir ? 1'b0 : ser);
                chk("shift_sl", sl, dir ? ser : 1'b0);
                chk("shift_b", b, 0);
                r = dir ? {r[W-2:0], ser} : {ser, r[W-1:1]};
            end else begin
                chk("done_state_s", s, 2'b00);
                chk("done_state_b", {sr, sl}, 0);
            end
            chk("busy_active", busy, 1);
            chk("no_early_done", cif.done, 0);
            if (p == abort_ph) abort = 1'b1;
            step();
            abort = 1'b0;
            if (p == abort_ph) begin
                chk("abort_idle", busy, 0);
                chk("abort_no_done", cif.done, 0);
                chk("abort_res_kept", cif.res_data, res_exp);
                return;
            end
        end
        res_exp = ref_result(d, dir, cnt, fill, rot);
        chk("done_pulse", cif.done, 1);
        chk("res_data", cif.res_data, res_exp);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_data  = '0;
        cif.cmd_dir   = 1'b0;
        cif.cmd_count = '0;
        cif.cmd_fill  = 1'b0;
        set_rot(1'b0);

        step();
        step();
        chk("rst_s", s, 0);
        chk("rst_b", b, 0);
        chk("rst_ready", cif.cmd_ready, 0);
        chk("rst_res", cif.res_data, 0);
        chk("rst_done", cif.done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", cif.cmd_ready, 1);

        run_job(4'b0101, 1'b0, 1, 1'b1, 1'b0, -1);
        chk("tp_right1", cif.res_data, 4'b1010);
        run_job(4'b0101, 1'b1, 2, 1'b0, 1'b0, -1);
        chk("tp_left2", cif.res_data, 4'b0100);
        run_job(4'b1001, 1'b0, 0, 1'b0, 1'b0, -1);
        chk("tp_count0", cif.res_data, 4'b1001);
        run_job(4'b0110, 1'b0, 5, 1'b1, 1'b0, 2);
        chk("tp_abort_keep", cif.res_data, 4'b1001);
        // Second job starts in the cycle the first job's done is high.
        run_job(4'b0011, 1'b1, 7, 1'b1, 1'b0, -1);
        chk("tp_overfill", cif.res_data, 4'b1111);
        run_job(4'b1100, 1'b0, 6, 1'b0, 1'b0, -1);
        chk("tp_b2b", cif.res_data, 4'b0000);
`ifdef USR_ROTATE_EN
        run_job(4'b0011, 1'b0, 1, 1'b0, 1'b1, -1);
        chk("tp_rotate", cif.res_data, 4'b1001);
`endif
        run_job(4'b1010, 1'b1, 3, 1'b1, 1'b0, 4);
        chk("abort_in_done", cif.res_data, 4'b0000);

        // Reset in the middle of a job clears the result.
        run_job(4'b1111, 1'b0, 1, 1'b1, 1'b0, -1);
        cif.cmd_valid = 1'b1;
        cif.cmd_data  = 4'b0110;
        cif.cmd_count = 3'd4;
        step();
        cif.cmd_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("midrst_busy", busy, 0);
        chk("midrst_res", cif.res_data, 0);
        chk("midrst_ready", cif.cmd_ready, 0);
        rst = 1'b1;
        res_exp = '0;

        for (int i = 0; i < 40; i++) begin
            logic         rot;
            int           cnt;
            int           ab;
            cnt = $urandom_range(0, 7);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, cnt + 1) : -1;
`ifdef USR_ROTATE_EN
            rot = 1'($urandom);
`else
            rot = 1'b0;
`endif
            run_job(W'($urandom), 1'($urandom), cnt, 1'($urandom), rot, ab);
            if ($urandom_range(0, 2) == 0) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
